cond_flag_unit: RTL and testbench

NZCV flag register and B.cond condition evaluator. Sits directly upstream of the PC branch-taken logic and produces its BCondCheck input.
- Captures flags from flag-setting EX-stage instructions (ADDS/SUBS/ANDS) into a one-deep pending register.
- Commits pending flags to the architectural NZCV register.
- Evaluates the 4-bit condition field of a decoded B.cond against the newest flags; the result is registered.

---
 rtl/cond_pkg.sv | 60 ++++++
 rtl/cond_eval_logic.sv | 16 +
 rtl/cond_flag_unit.sv | 92 +++++++++
 tb/tb_cond_flag_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code definitions: the B.cond encoding, NZCV bit positions
// and the condition evaluation function used by branch and conditional-select logic.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // NV behaves as AL, so both always pass.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic result;
    n = nzcv[N_BIT];
    z = nzcv[Z_BIT];
    c = nzcv[C_BIT];
    v = nzcv[V_BIT];
    case (cond_e'(cond))
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_HS: result = c;
      COND_LO: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = z | (n != v);
      default: result = 1'b1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cond_eval_logic.sv
// Purely combinational condition evaluator: 4-bit condition field against an
// NZCV value. Shared by B.cond resolution and conditional-select instructions.
module cond_eval_logic
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       result
);

  // Evaluate the condition against the supplied flags.
  always_comb begin
    result = cond_eval(cond, nzcv);
  end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register with a one-deep pending stage, plus the registered
// B.cond evaluator that feeds branch-taken logic (BCondCheck).
// Build option FLAG_FWD_EN: when defined, conditions see the newest flags via
// bypass from EX and the pending stage; when undefined, conditions see only the
// architectural flags and flag_stall holds the front end until they settle.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         COND_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              flag_we,
  input  logic [3:0]        alu_flags,
  input  logic              stall,
  input  logic              flush,
  input  logic              cond_valid,
  input  logic [COND_W-1:0] cond,
  output logic              BCondCheck,
  output logic              bcond_valid,
  output logic [3:0]        flags,
  output logic              flag_stall
);

  logic       exSetsFlags;
  logic       cap;
  logic       pendValid;
  logic [3:0] pendFlags;
  logic [3:0] evalFlags;
  logic       evalResult;
  logic       acceptCond;

  // A flushed EX instruction never writes flags; a stall defers capture.
  assign exSetsFlags = ex_valid & flag_we & ~flush;
  assign cap         = exSetsFlags & ~stall;

`ifdef FLAG_FWD_EN
  // Pick the youngest flag producer: EX result, then pending, then architectural.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    evalFlags = flags;
    if (exSetsFlags) begin
      evalFlags = alu_flags;
    end else if (pendValid) begin
      evalFlags = pendFlags;
    end
  end

  assign flag_stall = 1'b0;
`else
  assign evalFlags  = flags;
  // Hold the condition until no younger flag write is in flight.
  assign flag_stall = cond_valid & (pendValid | exSetsFlags);
`endif

  assign acceptCond = cond_valid & ~flag_stall;

  cond_eval_logic u_cond_eval (
    .cond   (cond),
    .nzcv   (evalFlags),
    .result (evalResult)
  );

  // Flag capture/commit pipeline and registered condition result; stall freezes all.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what lets commit and capture share a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags       <= RESET_FLAGS;
      pendValid   <= 1'b0;
      pendFlags   <= 4'b0000;
      BCondCheck  <= 1'b0;
      bcond_valid <= 1'b0;
    end else if (!stall) begin
      if (pendValid) begin
        flags <= pendFlags;
      end
      if (cap) begin
        pendFlags <= alu_flags;
        pendValid <= 1'b1;
      end else if (pendValid) begin
        pendValid <= 1'b0;
      end
      bcond_valid <= acceptCond;
      BCondCheck  <= acceptCond & evalResult;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed multi-cycle sequences plus a
// table of condition/NZCV vectors, with results matched through a scoreboard.
module tb_cond_flag_unit;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       ex_valid;
  logic       flag_we;
  logic [3:0] alu_flags;
  logic       stall;
  logic       flush;
  logic       cond_valid;
  logic [3:0] cond;
  logic       BCondCheck;
  logic       bcond_valid;
  logic [3:0] flags;
  logic       flag_stall;

  int nChecks = 0;
  int nFails  = 0;

  bit    expQ[$];
  string tagQ[$];

  typedef struct {
    logic [3:0] nzcv;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  cond_flag_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ex_valid    (ex_valid),
    .flag_we     (flag_we),
    .alu_flags   (alu_flags),
    .stall       (stall),
    .flush       (flush),
    .cond_valid  (cond_valid),
    .cond        (cond),
    .BCondCheck  (BCondCheck),
    .bcond_valid (bcond_valid),
    .flags       (flags),
    .flag_stall  (flag_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference condition table written straight from the architectural definitions.
  function automatic logic refEval(input logic [3:0] c, input logic [3:0] f);
    logic n;
    logic z;
    logic cy;
    logic v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0: return z == 1'b1;
      4'h1: return z == 1'b0;
      4'h2: return cy == 1'b1;
      4'h3: return cy == 1'b0;
      4'h4: return n == 1'b1;
      4'h5: return n == 1'b0;
      4'h6: return v == 1'b1;
      4'h7: return v == 1'b0;
      4'h8: return (cy == 1'b1) && (z == 1'b0);
      4'h9: return (cy == 1'b0) || (z == 1'b1);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return (z == 1'b0) && (n == v);
      4'hD: return (z == 1'b1) || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic pushExp(input bit e, input string tag);
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // One clock; if the edge was not stalled, match any produced result against the scoreboard.
  task automatic step();
    logic st;
    bit    e;
    string tag;
    st = stall;
    @(posedge clk);
    #1;
    if (st === 1'b0) begin
      if (bcond_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_result: got BCondCheck=%b with nothing expected", BCondCheck);
        end else begin
          e   = expQ.pop_front();
          tag = tagQ.pop_front();
          check(tag, 32'(BCondCheck), 32'(e));
        end
      end else begin
        check("idle_outputs_low", 32'({bcond_valid, BCondCheck}), 32'h0);
      end
    end
  endtask

  task automatic clearEx();
    ex_valid = 1'b0;
    flag_we  = 1'b0;
    flush    = 1'b0;
  endtask

  // Capture f and let it commit, leaving it architectural with nothing pending.
  task automatic loadFlags(input logic [3:0] f);
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    alu_flags = f;
    step();
    clearEx();
    step();
    check($sformatf("load_flags_%b", f), 32'(flags), 32'(f));
  endtask

  // Present a condition and hold it while flag_stall is high; counts stall cycles.
  task automatic issueCond(input logic [3:0] c, input bit exp, input int expStalls, input string name);
    int stalls;
    bit done;
    stalls     = 0;
    done       = 1'b0;
    cond_valid = 1'b1;
    cond       = c;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (flag_stall === 1'b0) begin
        pushExp(exp, name);
        step();
        done = 1'b1;
      end else begin
        step();
        stalls++;
      end
      clearEx();
    end
    cond_valid = 1'b0;
    if (!done) begin
      nChecks++;
      nFails++;
      $display("FAIL %s_timeout: got flag_stall stuck high, expected release within 8 cycles", name);
    end
    check({name, "_stalls"}, 32'(stalls), 32'(expStalls));
  endtask

  initial begin
    logic [3:0] cur;

    reset_n    = 1'b0;
    ex_valid   = 1'b0;
    flag_we    = 1'b0;
    alu_flags  = 4'b0000;
    stall      = 1'b0;
    flush      = 1'b0;
    cond_valid = 1'b0;
    cond       = 4'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_bcc", 32'(BCondCheck), 32'h0);
    check("reset_bvalid", 32'(bcond_valid), 32'h0);
    check("reset_flag_stall", 32'(flag_stall), 32'h0);
    reset_n = 1'b1;

    // Asynchronous reset with a pending write outstanding.
    loadFlags(4'b0110);
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    alu_flags = 4'b1001;
    step();
    clearEx();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_flags", 32'(flags), 32'h0);
    check("async_reset_bcc", 32'(BCondCheck), 32'h0);
    check("async_reset_bvalid", 32'(bcond_valid), 32'h0);
    #2 reset_n = 1'b1;
    step();
    check("pending_dropped_by_reset", 32'(flags), 32'h0);

    // SUBS (Z set) then B.EQ the following cycle.
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    alu_flags = 4'b0100;
    step();
    clearEx();
    check("subs_not_yet_committed", 32'(flags), 32'h0);
    issueCond(4'h0, 1'b1, FWD ? 0 : 1, "subs_beq");
    check("subs_committed", 32'(flags), 32'h4);

    // Back-to-back SUBS, B.MI alongside the second one.
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    alu_flags = 4'b0100;
    step();
    alu_flags = 4'b1000;
    issueCond(4'h4, 1'b1, FWD ? 0 : 2, "b2b_bmi");
    step();
    check("b2b_final_flags", 32'(flags), 32'h8);

    // Flushed flag write is ignored by both capture and evaluation.
    loadFlags(4'b0000);
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    flush     = 1'b1;
    alu_flags = 4'b0100;
    issueCond(4'h1, 1'b1, 0, "flush_bne");
    step();
    check("flush_no_capture", 32'(flags), 32'h0);

    // Flush does not block an older pending commit.
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    alu_flags = 4'b0011;
    step();
    flush     = 1'b1;
    alu_flags = 4'b1111;
    step();
    clearEx();
    check("flush_commit_proceeds", 32'(flags), 32'h3);
    step();
    check("flush_commit_stable", 32'(flags), 32'h3);

    // Stall freezes pending state and outputs; even a capture attempt is ignored.
    ex_valid  = 1'b1;
    flag_we   = 1'b1;
    alu_flags = 4'b0101;
    step();
    stall      = 1'b1;
    cond_valid = 1'b1;
    cond       = 4'h0;
    alu_flags  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_flags_%0d", i), 32'(flags), 32'h3);
      check($sformatf("stall_outputs_%0d", i), 32'({bcond_valid, BCondCheck}), 32'h0);
    end
    stall = 1'b0;
    clearEx();
    issueCond(4'h0, 1'b1, FWD ? 0 : 1, "stall_release_beq");
    check("stall_release_commit", 32'(flags), 32'h5);

    // A produced result holds through a stall.
    cond_valid = 1'b1;
    cond       = 4'h0;
    pushExp(1'b1, "hold_beq");
    step();
    stall = 1'b1;
    cond  = 4'h1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("hold_outputs_%0d", i), 32'({bcond_valid, BCondCheck}), 32'h3);
    end
    stall      = 1'b0;
    cond_valid = 1'b0;
    step();

    // Condition table: spot checks first, then the full sweep.
    vecs.push_back('{nzcv: 4'b1001, cond: 4'hA, exp: 1'b1});
    vecs.push_back('{nzcv: 4'b1001, cond: 4'hB, exp: 1'b0});
    vecs.push_back('{nzcv: 4'b0100, cond: 4'hD, exp: 1'b1});
    vecs.push_back('{nzcv: 4'b0110, cond: 4'h8, exp: 1'b0});
    vecs.push_back('{nzcv: 4'b0010, cond: 4'h9, exp: 1'b0});
    vecs.push_back('{nzcv: 4'b0001, cond: 4'hC, exp: 1'b0});
    vecs.push_back('{nzcv: 4'b0000, cond: 4'hF, exp: 1'b1});
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        vecs.push_back('{nzcv: 4'(f), cond: 4'(c), exp: refEval(4'(c), 4'(f))});
      end
    end

    cur = 4'bxxxx;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].nzcv !== cur) begin
        cond_valid = 1'b0;
        loadFlags(vecs[i].nzcv);
        cur = vecs[i].nzcv;
      end
      cond_valid = 1'b1;
      cond       = vecs[i].cond;
      pushExp(vecs[i].exp, $sformatf("table_cond%0h_nzcv%b", vecs[i].cond, vecs[i].nzcv));
      step();
    end
    cond_valid = 1'b0;
    repeat (2) step();

    check("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
